neuromorphic_x1_arbiter: RTL

- Two-requester round-robin arbiter and transaction sequencer in front of one NEUROMORPHIC_X1 macro.
- Serialises read/write accesses from port 0 (host bus bridge) and port 1 (inference sequencer) onto the macro's EN/R_WB/func_ack handshake.
- Watchdog terminates any access the macro fails to acknowledge.
- Sits between the user-project bus fabric and the macro instance; same clock domain as the macro.

---
 rtl/neuromorphic_x1_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/neuromorphic_x1_arbiter.sv
// neuromorphic_x1_arbiter: round-robin two-port arbiter and watchdog-guarded sequencer for one NEUROMORPHIC_X1 macro.
// Define NEUROMORPHIC_X1_ARB_STATS_EN to add saturating transaction/timeout counters.
module neuromorphic_x1_arbiter #(
  parameter  int TIMEOUT = 64,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_sel,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_sel,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mac_EN,
  output logic        mac_R_WB,
  output logic [31:0] mac_DI,
  output logic [31:0] mac_AD,
  output logic [3:0]  mac_SEL,
  input  logic [31:0] mac_DO,
  input  logic        mac_func_ack
`ifdef NEUROMORPHIC_X1_ARB_STATS_EN
  ,
  output logic [15:0] stat_txn,
  output logic [15:0] stat_timeout
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic        ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [TW-1:0] wd_q, wd_d;
  logic        en_q, en_d, rwb_q, rwb_d;
  logic [31:0] di_q, di_d, ad_q, ad_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wd_d    = wd_q;
    en_d    = en_q;
    rwb_d   = rwb_q;
    di_d    = di_q;
    ad_d    = ad_q;
    sel_d   = sel_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    pick    = ptr_q ? p1_req : !p0_req;
    if (state_q == IDLE) begin
      if (p0_req || p1_req) begin
        gnt_d   = pick;
        rwb_d   = pick ? !p1_we : !p0_we;
        di_d    = pick ? p1_wdata : p0_wdata;
        ad_d    = pick ? p1_addr : p0_addr;
        sel_d   = pick ? p1_sel : p0_sel;
        en_d    = 1'b1;
        wd_d    = '0;
        state_d = BUSY;
      end
    end else if (mac_func_ack || wd_q == TW'(TIMEOUT - 1)) begin
      // func_ack takes precedence over a coinciding watchdog expiry
      en_d    = 1'b0;
      ack0_d  = !gnt_q;
      ack1_d  = gnt_q;
      err0_d  = !gnt_q && !mac_func_ack;
      err1_d  = gnt_q && !mac_func_ack;
      rd0_d   = (mac_func_ack && rwb_q && !gnt_q) ? mac_DO : rd0_q;
      rd1_d   = (mac_func_ack && rwb_q && gnt_q) ? mac_DO : rd1_q;
      ptr_d   = !gnt_q;
      state_d = IDLE;
    end else begin
      wd_d = wd_q + TW'(1);
    end
  end
  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      rwb_q   <= 1'b0;
      di_q    <= '0;
      ad_q    <= '0;
      sel_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      rwb_q   <= rwb_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
`ifdef NEUROMORPHIC_X1_ARB_STATS_EN
  logic [15:0] txn_q, tmo_q;
  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      txn_q <= '0;
      tmo_q <= '0;
    end else begin
      txn_q <= ((ack0_d || ack1_d) && txn_q != 16'hFFFF) ? txn_q + 16'd1 : txn_q;
      tmo_q <= ((err0_d || err1_d) && tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
    end
  end
  assign stat_txn     = txn_q;
  assign stat_timeout = tmo_q;
`endif
  assign mac_EN   = en_q;
  assign mac_R_WB = rwb_q;
  assign mac_DI   = di_q;
  assign mac_AD   = ad_q;
  assign mac_SEL  = sel_q;
  assign p0_ack   = ack0_q;
  assign p1_ack   = ack1_q;
  assign p0_err   = err0_q;
  assign p1_err   = err1_q;
  assign p0_rdata = rd0_q;
  assign p1_rdata = rd1_q;
endmodule
